leap_scoreboard: RTL and testbench
==================================

// Module: leap_scoreboard
// PURPOSE
//  Multi-miss successor to the single-miss leap check in the RV32I pipeline.
//  - Tracks up to DEPTH outstanding data-cache misses issued from MA. Misses resolve in order.
//  - Each cycle, decides whether the instruction in EX is independent of every pending load
//    and may "leap" (advance and retire) while the misses are serviced.
//  - Sits beside the hazard unit. Its stall output gates the IF/ID/EX pipeline registers.
// PARAMETERS
//  DEPTH     2  max outstanding misses (FIFO entries), >=1
//  MAX_LEAP  4  max instructions allowed to leap per miss window, >=1
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       synchronous reset, active-low
//  ex_valid      in   1       EX holds a real instruction
//  ex_instr      in   32      EX instruction word (rs1=[19:15], rs2=[24:20], rd=[11:7])
//  ex_opcode     in   rv32i_opcode  EX opcode from control word
//  miss_start    in   1       MA load/store missed this cycle; push entry
//  miss_is_load  in   1       pushed miss is a load (store: no rd hazard)
//  miss_rd       in   5       rd of pushed load
//  miss_done     in   1       oldest miss response returned; pop entry
//  leap          out  1       EX instruction may advance past pending misses
//  stall         out  1       hold IF..EX (misses pending and leap=0)
//  full          out  1       DEPTH entries valid
//  pending       out  $clog2(DEPTH+1)  number of valid entries
//  leap_cnt      out  $clog2(MAX_LEAP+1)  leaps used in current window
// BEHAVIOUR
//  Reset (rst=0 at edge): all entries invalid, state=IDLE.
//   - leap=0, stall=0, full=0, pending=0, leap_cnt=0.
//   - Reset mid-window discards all entries; no pop is expected afterwards.
//  FIFO: circular, head/tail pointers wrap at DEPTH.
//   - Push on miss_start, pop on miss_done.
//   - Push and pop in the same cycle: both happen, pending unchanged (allowed when full).
//   - Push while full without pop: ignored (protocol error, flagged by an assertion).
//   - Pop while empty: ignored.
//  Source use (by ex_opcode):
//   - lui, auipc, jal: none.
//   - jalr, load, imm: rs1.
//   - all others: rs1 and rs2.
//  Hazard: a valid pending load entry whose rd!=0 and rd equals a used source or EX rd (WAW).
//   - rd=x0 never hazards.
//   - Store entries never hazard.
//  leap (combinational) = 1 only when all of the following hold:
//   - state==MISS and ex_valid
//   - ex_instr!=32'h00000013 (NOP)
//   - ex_opcode not load/store/br/jal/jalr (no memory ops, no control flow past a miss)
//   - no hazard
//   - leap_cnt<MAX_LEAP
//  stall = (pending!=0) & ~leap.
//  leap_cnt:
//   - increments on each cycle leap=1.
//   - clears to 0 when pending becomes 0 (the window ends).
//   - saturates at MAX_LEAP.
//  FSM (registered; transitions take effect next cycle):
//   IDLE  -> MISS  : push accepted
//   MISS  -> BLOCK : leap_cnt reaches MAX_LEAP, or full with no pop
//   MISS  -> IDLE  : pending drops to 0
//   BLOCK -> MISS  : pop leaves entries and leap_cnt<MAX_LEAP
//   BLOCK -> IDLE  : pending drops to 0
//   In IDLE and BLOCK: leap=0.
//  Latency:
//   - leap/stall are same-cycle from EX inputs.
//   - A pushed entry affects leap starting the cycle after miss_start.
//   - A popped entry stops hazarding the cycle after miss_done.
// STRUCTURE
//  rv32i_types additions:
//   - leap_state_t enum {IDLE, MISS, BLOCK}.
//   - leap_entry_t struct {valid, is_load, rd[4:0]}.
//   - NOP_INSTR = 32'h00000013.
//  One sub-module: leap_src_decode (combinational).
//   - Maps ex_opcode/ex_instr to use_rs1, use_rs2, rs1, rs2, rd.
//  Top level: FIFO array + pointers, hazard compare loop over DEPTH, leap counter, FSM.
// TESTING
//  1. Reset asserted mid-window with pending=2 -> next cycle pending=0, leap=0, stall=0, state=IDLE.
//  2. Load miss rd=x5, then EX add x7,x6,x8 -> leap=1, stall=0.
//     EX add x7,x5,x8 -> leap=0, stall=1.
//  3. Load miss rd=x0, then EX uses x0 -> leap=1.
//     Store miss, then EX uses any reg -> leap=1.
//  4. DEPTH=2: two misses pushed (full=1), third push with simultaneous pop -> pending stays 2.
//     Pop order is FIFO: the older rd stops hazarding first.
//  5. MAX_LEAP=4: five independent ALU ops after one miss -> first four leap=1.
//     Fifth: leap=0, state=BLOCK. miss_done -> IDLE, leap_cnt=0.
//  6. Independent beq or lw in EX during MISS -> leap=0.
//     NOP 32'h00000013 -> leap=0.

Source files
------------

// File: rtl/leap_scoreboard_pkg.sv
// Shared types for the multi-miss leap scoreboard: RV32I opcodes, FSM states,
// miss FIFO entry layout and the canonical NOP encoding.
package leap_scoreboard_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    BLOCK = 2'd2
  } leap_state_t;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [4:0] rd;
  } leap_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Memory ops and control flow must never run ahead of an unresolved miss.
  function automatic logic is_barrier_op(input rv32i_opcode op);
    return (op == op_load) || (op == op_store) || (op == op_br) ||
           (op == op_jal)  || (op == op_jalr);
  endfunction

endpackage

// File: rtl/leap_scoreboard_src_decode.sv
// Register-field decode for the EX instruction: which sources are read and
// whether rd is written, so only real dependencies are compared against misses.
module leap_src_decode
  import leap_scoreboard_pkg::*;
(
  input  rv32i_opcode opcode,
  input  logic [31:0] instr,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        use_rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic unused_bits;
  assign unused_bits = ^{instr[31:25], instr[14:12], instr[6:0]};

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b1;
    use_rd  = 1'b1;
    case (opcode)
      op_lui, op_auipc, op_jal: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      op_jalr, op_load, op_imm: begin
        use_rs2 = 1'b0;
      end
      // [11:7] holds immediate bits here, not a destination
      op_store, op_br: begin
        use_rd = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/leap_scoreboard.sv
// In-order multi-miss scoreboard: lets independent EX instructions leap past
// pending data-cache misses, bounded by MAX_LEAP per window; otherwise stalls IF..EX.
module leap_scoreboard
  import leap_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_LEAP = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_valid,
  input  logic [31:0]                   ex_instr,
  input  rv32i_opcode                   ex_opcode,
  input  logic                          miss_start,
  input  logic                          miss_is_load,
  input  logic [4:0]                    miss_rd,
  input  logic                          miss_done,
  output logic                          leap,
  output logic                          stall,
  output logic                          full,
  output logic [$clog2(DEPTH+1)-1:0]    pending,
  output logic [$clog2(MAX_LEAP+1)-1:0] leap_cnt
);

  localparam int PEND_W = $clog2(DEPTH + 1);
  localparam int CNT_W  = $clog2(MAX_LEAP + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  leap_entry_t       fifo [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PEND_W-1:0] count, count_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  leap_state_t       state, state_nxt;

  logic push_ok, pop_ok, hazard;
  logic use_rs1, use_rs2, use_rd;
  logic [4:0] rs1, rs2, rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  leap_src_decode u_decode (
    .opcode  (ex_opcode),
    .instr   (ex_instr),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .use_rd  (use_rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd)
  );

  assign full    = (count == PEND_W'(DEPTH));
  assign pop_ok  = miss_done & (count != '0);
  // A full FIFO can still accept a push when the oldest entry leaves the same cycle.
  assign push_ok = miss_start & (~full | pop_ok);
  assign count_nxt = count + PEND_W'(push_ok) - PEND_W'(pop_ok);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo[i].valid && fifo[i].is_load && (fifo[i].rd != 5'd0)) begin
        if ((use_rs1 && (fifo[i].rd == rs1)) ||
            (use_rs2 && (fifo[i].rd == rs2)) ||
            (use_rd  && (fifo[i].rd == rd)))
          hazard = 1'b1;
      end
    end
  end

  assign leap = (state == MISS) && ex_valid && (ex_instr != NOP_INSTR) &&
                !is_barrier_op(ex_opcode) && !hazard &&
                (cnt < CNT_W'(MAX_LEAP));
  assign stall = (count != '0) & ~leap;

  always_comb begin
    cnt_nxt = cnt;
    if (count_nxt == '0)
      cnt_nxt = '0;
    else if (leap)
      cnt_nxt = cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (push_ok)
          state_nxt = MISS;
      end
      MISS: begin
        if (count_nxt == '0)
          state_nxt = IDLE;
        else if ((cnt_nxt == CNT_W'(MAX_LEAP)) || (full && !pop_ok))
          state_nxt = BLOCK;
      end
      BLOCK: begin
        if (count_nxt == '0)
          state_nxt = IDLE;
        else if (pop_ok && (cnt_nxt < CNT_W'(MAX_LEAP)))
          state_nxt = MISS;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++)
        fifo[i] <= '0;
    end else begin
      if (pop_ok) begin
        fifo[head].valid <= 1'b0;
        head             <= ptr_inc(head);
      end
      // Ordered after the pop so a full push+pop at head==tail keeps the new entry.
      if (push_ok) begin
        fifo[tail] <= '{valid: 1'b1, is_load: miss_is_load, rd: miss_rd};
        tail       <= ptr_inc(tail);
      end
      count <= count_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign pending  = count;
  assign leap_cnt = cnt;

  push_when_full: assert property (@(posedge clk) disable iff (!rst)
                                   !(miss_start && full && !miss_done));

endmodule

// File: tb/tb_leap_scoreboard.sv
// Randomized and directed checks of leap_scoreboard against a queue-based model
// of the outstanding-miss window.
module tb_leap_scoreboard;
  import leap_scoreboard_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_LEAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_instr = 32'h0;
  rv32i_opcode ex_opcode = op_reg;
  logic        miss_start = 1'b0;
  logic        miss_is_load = 1'b0;
  logic [4:0]  miss_rd = 5'd0;
  logic        miss_done = 1'b0;
  logic        leap, stall, full;
  logic [1:0]  pending;
  logic [2:0]  leap_cnt;

  leap_scoreboard #(.DEPTH(DEPTH), .MAX_LEAP(MAX_LEAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_instr     (ex_instr),
    .ex_opcode    (ex_opcode),
    .miss_start   (miss_start),
    .miss_is_load (miss_is_load),
    .miss_rd      (miss_rd),
    .miss_done    (miss_done),
    .leap         (leap),
    .stall        (stall),
    .full         (full),
    .pending      (pending),
    .leap_cnt     (leap_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: window of outstanding misses, oldest first; state 0=IDLE 1=MISS 2=BLOCK.
  typedef struct { bit ld; int rd; } ent_t;
  ent_t q[$];
  int   m_cnt   = 0;
  int   m_state = 0;
  bit   m_leap;

  function automatic bit model_leap();
    bit u1, u2, ud, haz;
    int s1, s2, d;
    s1 = int'(ex_instr[19:15]);
    s2 = int'(ex_instr[24:20]);
    d  = int'(ex_instr[11:7]);
    u1 = !(ex_opcode inside {op_lui, op_auipc, op_jal});
    u2 = !(ex_opcode inside {op_lui, op_auipc, op_jal, op_jalr, op_load, op_imm});
    ud = !(ex_opcode inside {op_store, op_br});
    haz = 0;
    foreach (q[i])
      if (q[i].ld && q[i].rd != 0 &&
          ((u1 && q[i].rd == s1) || (u2 && q[i].rd == s2) || (ud && q[i].rd == d)))
        haz = 1;
    return (m_state == 1) && ex_valid && (ex_instr != 32'h00000013) &&
           !(ex_opcode inside {op_load, op_store, op_br, op_jal, op_jalr}) &&
           !haz && (m_cnt < MAX_LEAP);
  endfunction

  task automatic model_edge();
    bit prev_full, pop, push;
    if (!rst) begin
      q.delete();
      m_cnt = 0;
      m_state = 0;
      return;
    end
    prev_full = (q.size() == DEPTH);
    pop  = miss_done && (q.size() > 0);
    push = miss_start && (!prev_full || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{ld: miss_is_load, rd: int'(miss_rd)});
    if (q.size() == 0) m_cnt = 0;
    else if (m_leap) m_cnt++;
    case (m_state)
      0: if (push) m_state = 1;
      1: if (q.size() == 0) m_state = 0;
         else if (m_cnt == MAX_LEAP || (prev_full && !pop)) m_state = 2;
      2: if (q.size() == 0) m_state = 0;
         else if (pop && m_cnt < MAX_LEAP) m_state = 1;
      default: m_state = 0;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    m_leap = model_leap();
    chk("leap", int'(leap), int'(m_leap));
    chk("stall", int'(stall), int'((q.size() != 0) && !m_leap));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("pending", int'(pending), q.size());
    chk("leap_cnt", int'(leap_cnt), m_cnt);
    chk("state", int'(dut.state), m_state);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2,
                                     input rv32i_opcode op);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), 7'(op)};
  endfunction

  task automatic drive(input bit st, input bit ld, input int rd, input bit dn,
                       input bit v, input rv32i_opcode op, input logic [31:0] ins);
    miss_start = st; miss_is_load = ld; miss_rd = 5'(rd); miss_done = dn;
    ex_valid = v; ex_opcode = op; ex_instr = ins;
    step();
  endtask

  task automatic ex_only(input rv32i_opcode op, input logic [31:0] ins);
    drive(0, 0, 0, 0, 1, op, ins);
  endtask

  initial begin
    logic [31:0] r;
    rv32i_opcode ops [10] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                              op_load, op_store, op_imm, op_reg, op_csr};
    step();
    rst = 1'b1;
    step();

    // Independent vs dependent add behind a load miss to x5.
    drive(1, 1, 5, 0, 0, op_reg, 32'h0);
    ex_only(op_reg, mk(7, 6, 8, op_reg));
    ex_only(op_reg, mk(7, 5, 8, op_reg));
    drive(0, 0, 0, 1, 0, op_reg, 32'h0);

    // x0 destination and store misses never hazard.
    drive(1, 1, 0, 0, 0, op_reg, 32'h0);
    ex_only(op_reg, mk(1, 0, 0, op_reg));
    drive(0, 0, 0, 1, 0, op_reg, 32'h0);
    drive(1, 0, 5, 0, 0, op_reg, 32'h0);
    ex_only(op_reg, mk(5, 5, 5, op_reg));
    drive(0, 0, 0, 1, 0, op_reg, 32'h0);

    // Branches, loads and NOPs are held back during a miss.
    drive(1, 1, 9, 0, 0, op_reg, 32'h0);
    ex_only(op_br, mk(0, 1, 2, op_br));
    ex_only(op_load, mk(3, 1, 0, op_load));
    ex_only(op_imm, NOP_INSTR);
    drive(0, 0, 0, 1, 0, op_reg, 32'h0);

    // Full FIFO, push with simultaneous pop, then in-order release.
    drive(1, 1, 5, 0, 0, op_reg, 32'h0);
    drive(1, 1, 6, 0, 0, op_reg, 32'h0);
    drive(1, 1, 7, 1, 1, op_reg, mk(1, 5, 2, op_reg));
    ex_only(op_reg, mk(1, 5, 2, op_reg));
    ex_only(op_reg, mk(1, 6, 2, op_reg));
    drive(0, 0, 0, 1, 1, op_reg, mk(1, 6, 2, op_reg));
    ex_only(op_reg, mk(1, 6, 2, op_reg));
    ex_only(op_reg, mk(1, 7, 2, op_reg));
    drive(0, 0, 0, 1, 0, op_reg, 32'h0);

    // Leap budget exhaustion.
    drive(1, 1, 5, 0, 0, op_reg, 32'h0);
    for (int i = 0; i < 5; i++) ex_only(op_reg, mk(1, 2, 3, op_reg));
    drive(0, 0, 0, 1, 0, op_reg, 32'h0);
    drive(0, 0, 0, 0, 0, op_reg, 32'h0);

    // Reset with two misses outstanding.
    drive(1, 1, 5, 0, 0, op_reg, 32'h0);
    drive(1, 1, 6, 0, 0, op_reg, 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, op_reg, mk(1, 2, 3, op_reg));
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, op_reg, mk(1, 2, 3, op_reg));

    for (int n = 0; n < 600; n++) begin
      bit st, dn;
      r = $urandom;
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      r[11:7]  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) r = NOP_INSTR;
      dn = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 2) == 0);
      if (q.size() == DEPTH && !dn) st = 0;
      rst = ($urandom_range(0, 99) != 0);
      drive(st, $urandom_range(0, 3) != 0, $urandom_range(0, 7), dn,
            $urandom_range(0, 3) != 0, ops[$urandom_range(0, 9)], r);
      rst = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
